cla_seq_add_ctrl: RTL and testbench



---
 rtl/cla_seq_add_ctrl.sv | 143 ++++++++++++++
 tb/tb_cla_seq_add_ctrl.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cla_seq_add_ctrl.sv
// cla_seq_add_ctrl: wide adder built from one 4-bit carry-lookahead slice.
// One nibble is added per clock, LSB nibble first, with the inter-nibble
// carry kept in a register. Operands arrive over a valid/ready handshake and
// the result leaves over another one.
// Optional feature: define CLA_SEQ_SUB_EN to add a 'sub' input that turns the
// operation into a - b (B inverted, carry seeded with 1).
module cla_seq_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [4*NIBBLES-1:0] a,
  input  logic [4*NIBBLES-1:0] b,
  input  logic                 cin,
`ifdef CLA_SEQ_SUB_EN
  input  logic                 sub,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*NIBBLES-1:0] sum,
  output logic                 cout,
  output logic                 busy
);

  localparam int W  = 4 * NIBBLES;
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  logic [W-1:0]  a_reg;
  logic [W-1:0]  b_reg;
  logic          carry_reg;
  logic [IW-1:0] idx;

  logic          op_sub;
  logic [3:0]    nib_a;
  logic [3:0]    nib_b;
  logic [3:0]    g;
  logic [3:0]    p;
  logic [4:0]    c;
  logic [3:0]    cla_s;

`ifdef CLA_SEQ_SUB_EN
  assign op_sub = sub;
`else
  assign op_sub = 1'b0;
`endif

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    nib_a = 4'h0;
    nib_b = 4'h0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (idx == IW'(n)) begin
        nib_a = a_reg[4*n +: 4];
        nib_b = b_reg[4*n +: 4];
      end
    end
  end

  // 4-bit carry-lookahead slice: all carries computed directly from g/p.
  always_comb begin
    g    = nib_a & nib_b;
    p    = nib_a ^ nib_b;
    c[0] = carry_reg;
    c[1] = g[0] | (p[0] & c[0]);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
         | (p[2] & p[1] & p[0] & c[0]);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
         | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & c[0]);
    cla_s = p ^ c[3:0];
  end

  // Sequencing FSM with registered handshake outputs and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      idx       <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= a;
            b_reg     <= op_sub ? ~b : b;
            carry_reg <= op_sub ? 1'b1 : cin;
            idx       <= '0;
            sum       <= '0;
            in_ready  <= 1'b0;
            busy      <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (idx == IW'(n)) begin
              sum[4*n +: 4] <= cla_s;
            end
          end
          carry_reg <= c[4];
          if (idx == LAST_IDX) begin
            cout      <= c[4];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cla_seq_add_ctrl.sv
// tb_cla_seq_add_ctrl: randomized and directed bench for cla_seq_add_ctrl.
// A transaction-level model (exact a+b+cin arithmetic and an edge counter
// since acceptance) predicts the handshake outputs and the result every cycle.
// Define CLA_SEQ_SUB_EN to exercise the subtract build.
module tb_cla_seq_add_ctrl;

  localparam int NIBBLES = 4;
  localparam int W = 4 * NIBBLES;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub_drv;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int errors = 0;
  int checks = 0;

  cla_seq_add_ctrl #(.NIBBLES(NIBBLES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef CLA_SEQ_SUB_EN
    .sub       (sub_drv),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard time limit so the run always ends.
  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction model: pending op, edges since acceptance, exact result.
  bit         m_pending = 1'b0;
  int         m_age = 0;
  logic [W:0] m_exp = '0;

  // Advance the model at each edge from the inputs seen at that edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending = 1'b0;
      m_age = 0;
    end else if (!m_pending) begin
      if (in_valid === 1'b1) begin
        m_pending = 1'b1;
        m_age = 0;
        if (sub_drv)
          m_exp = {1'b0, a} + {1'b0, ~b} + (W+1)'(1);
        else
          m_exp = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
      end
    end else if (m_age < NIBBLES) begin
      m_age++;
    end else if (out_ready === 1'b1) begin
      m_pending = 1'b0;
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      checkOutput("rst_in_ready", in_ready, 1);
      checkOutput("rst_out_valid", out_valid, 0);
      checkOutput("rst_busy", busy, 0);
      checkOutput("rst_sum", sum, 0);
      checkOutput("rst_cout", cout, 0);
    end else begin
      checkOutput("in_ready", in_ready, !m_pending);
      checkOutput("busy", busy, m_pending);
      checkOutput("out_valid", out_valid, m_pending && (m_age == NIBBLES));
      if (m_pending && (m_age == NIBBLES)) begin
        checkOutput("sum", sum, m_exp[W-1:0]);
        checkOutput("cout", cout, m_exp[W]);
      end
    end
  end

  // One full directed operation with literal expected results and latency.
  task automatic applyStimulus(input string nm, input logic [W-1:0] ta, input logic [W-1:0] tb,
                               input logic tcin, input logic tsub, input int hold,
                               input logic [W-1:0] esum, input logic ecout);
    int lat;
    lat = 0;
    @(posedge clk); #2;
    a = ta; b = tb; cin = tcin; sub_drv = tsub; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #2;
    in_valid = 1'b0; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    for (int k = 1; k <= 50; k++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = k;
        break;
      end
    end
    checkOutput({nm, "_latency"}, lat, NIBBLES);
    checkOutput({nm, "_sum"}, sum, esum);
    checkOutput({nm, "_cout"}, cout, ecout);
    repeat (hold) begin
      @(posedge clk); #2;
      in_valid = 1'($urandom); a = W'($urandom); b = W'($urandom);
    end
    if (hold > 0) begin
      checkOutput({nm, "_held_sum"}, sum, esum);
      checkOutput({nm, "_held_cout"}, cout, ecout);
      checkOutput({nm, "_held_in_ready"}, in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    checkOutput({nm, "_release_out_valid"}, out_valid, 0);
    checkOutput({nm, "_release_in_ready"}, in_ready, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    in_valid = 1'($urandom); out_ready = 1'($urandom);
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub_drv = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_sum", sum, 0);
    checkOutput("reset_cout", cout, 0);
    #1;
    in_valid = 1'b0; out_ready = 1'b0;
    rst_n = 1'b1;

    applyStimulus("basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 0, 16'h5555, 1'b0);
    applyStimulus("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 0, 16'h0000, 1'b1);
    applyStimulus("backpressure", 16'h8000, 16'h8000, 1'b0, 1'b0, 5, 16'h0000, 1'b1);

    // Reset in the middle of RUN discards the operation.
    @(posedge clk); #2;
    a = 16'hABCD; b = 16'h1111; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrun_out_valid", out_valid, 0);
    checkOutput("midrun_in_ready", in_ready, 1);
    checkOutput("midrun_busy", busy, 0);
    checkOutput("midrun_sum", sum, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      checkOutput("midrun_no_result", out_valid, 0);
    end
    applyStimulus("after_reset", 16'h0001, 16'h0001, 1'b0, 1'b0, 0, 16'h0002, 1'b0);

`ifdef CLA_SEQ_SUB_EN
    applyStimulus("sub_borrow", 16'h0005, 16'h0007, 1'b1, 1'b1, 0, 16'hFFFE, 1'b0);
    applyStimulus("sub_noborrow", 16'h0007, 16'h0005, 1'b0, 1'b1, 1, 16'h0002, 1'b1);
    applyStimulus("sub_off_add", 16'h00F0, 16'h0010, 1'b1, 1'b0, 0, 16'h0101, 1'b0);
`endif

    // Random traffic with occasional resets, checked by the model.
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(posedge clk); #2;
      rst_n = ($urandom_range(0, 80) != 0);
      in_valid = 1'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
`ifdef CLA_SEQ_SUB_EN
      sub_drv = 1'($urandom);
`endif
    end
    @(posedge clk); #2;
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2 * NIBBLES + 4) @(posedge clk);
    @(negedge clk); #1;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
